// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, funct and ALU control constants for mips_control_unit
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALUOp/Funct to ALUControl decoder
//   alu_op        in  2  ALUOp from the main decoder
//   funct         in  6  instruction function field (only read when alu_op selects it)
//   alu_control   out 3  ALU operation code
//   funct_illegal out 1  alu_op selects Funct but Funct is not supported
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    // Funct is only inspected inside the ALUOP_FUNCT branch so an unknown
    // Funct on lw/sw/beq cannot reach either output.
    always_comb begin
        alu_control   = ALU_AND;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_control_unit.sv
// rtl/mips_control_unit.sv - registered main control decoder for the single-issue MIPS datapath
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   capture enable; 0 holds every output
//   Op, Funct            instruction opcode and function field
//   RegDst..Jump         registered datapath control bits
//   ALUControl           registered 3-bit ALU operation
//   Illegal              registered unsupported-instruction flag
// Optional feature macro: CTRL_UNIT_IMM_JUMP_EN (adds addi and j decode)
module mips_control_unit
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Branch,
    output logic       Jump,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    logic       reg_dst_d, alu_src_d, mem_to_reg_d, reg_write_d;
    logic       mem_write_d, branch_d, jump_d, op_illegal, is_rtype;
    alu_op_t    alu_op;
    logic [2:0] alu_control_raw;
    logic       funct_illegal;
    logic       illegal_d;

    always_comb begin
        reg_dst_d    = 1'b0;
        alu_src_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        op_illegal   = 1'b0;
        is_rtype     = 1'b0;
        alu_op       = ALUOP_ADD;
        case (Op)
            OP_RTYPE: begin
                is_rtype    = 1'b1;
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
                alu_op      = ALUOP_FUNCT;
            end
            OP_LW: begin
                alu_src_d    = 1'b1;
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
            end
            OP_SW: begin
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            OP_BEQ: begin
                branch_d = 1'b1;
                alu_op   = ALUOP_SUB;
            end
`ifdef CTRL_UNIT_IMM_JUMP_EN
            OP_ADDI: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
            end
            OP_J: begin
                jump_d = 1'b1;
            end
`endif
            default: op_illegal = 1'b1;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (Funct),
        .alu_control   (alu_control_raw),
        .funct_illegal (funct_illegal)
    );

    // is_rtype gates funct_illegal so Funct only matters for R-type.
    assign illegal_d = op_illegal | (is_rtype & funct_illegal);

    // An illegal instruction clears every control bit, write enables included.
    // Jump reports ALUControl 000 even though its ALUOp default decodes to add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegDst     <= 1'b0;
            ALUSrc     <= 1'b0;
            MemtoReg   <= 1'b0;
            RegWrite   <= 1'b0;
            MemWrite   <= 1'b0;
            Branch     <= 1'b0;
            Jump       <= 1'b0;
            ALUControl <= 3'b000;
            Illegal    <= 1'b0;
        end else if (en) begin
            RegDst     <= reg_dst_d    & ~illegal_d;
            ALUSrc     <= alu_src_d    & ~illegal_d;
            MemtoReg   <= mem_to_reg_d & ~illegal_d;
            RegWrite   <= reg_write_d  & ~illegal_d;
            MemWrite   <= mem_write_d  & ~illegal_d;
            Branch     <= branch_d     & ~illegal_d;
            Jump       <= jump_d       & ~illegal_d;
            ALUControl <= (illegal_d || jump_d) ? 3'b000 : alu_control_raw;
            Illegal    <= illegal_d;
        end
    end

endmodule

// File: tb/tb_mips_control_unit.sv
// tb/tb_mips_control_unit.sv - self-checking bench for mips_control_unit
module tb_mips_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, Jump, Illegal;
    logic [2:0] ALUControl;

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q;
    logic [10:0] obs;

    always #5 clk = ~clk;

    mips_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .Op         (Op),
        .Funct      (Funct),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .Jump       (Jump),
        .ALUControl (ALUControl),
        .Illegal    (Illegal)
    );

    // {RegDst,ALUSrc,MemtoReg,RegWrite,MemWrite,Branch,Jump,ALUControl,Illegal}
    assign obs = {RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, Jump, ALUControl, Illegal};

    localparam logic [10:0] ILL = 11'b0000000_000_1;

    logic [5:0] funct_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] alu_tab   [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

`ifdef CTRL_UNIT_IMM_JUMP_EN
    localparam bit IMM_JUMP = 1'b1;
`else
    localparam bit IMM_JUMP = 1'b0;
`endif

    // Reference: instruction-level table of what each instruction does.
    function automatic logic [10:0] model(input logic [5:0] op, input logic [5:0] funct);
        logic [10:0] r;
        r = ILL;
        if (op == 6'd0) begin
            for (int i = 0; i < 5; i++)
                if (funct === funct_tab[i]) r = {7'b1001000, alu_tab[i], 1'b0};
        end else if (op == 6'd35) r = {7'b0111000, 3'b010, 1'b0};
        else if (op == 6'd43)     r = {7'b0100100, 3'b010, 1'b0};
        else if (op == 6'd4)      r = {7'b0000010, 3'b110, 1'b0};
        else if (op == 6'd8 && IMM_JUMP) r = {7'b0101000, 3'b010, 1'b0};
        else if (op == 6'd2 && IMM_JUMP) r = {7'b0000001, 3'b000, 1'b0};
        return r;
    endfunction

    task automatic check(input string tag, input logic [10:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
    endtask

    task automatic step(input string tag, input logic e, input logic [5:0] op, input logic [5:0] funct);
        @(negedge clk);
        en = e; Op = op; Funct = funct;
        @(posedge clk);
        #1;
        if (e) exp_q = model(op, funct);
        check(tag, exp_q);
    endtask

    initial begin
        logic [5:0] op_pool [8];
        logic [5:0] op_r, fn_r;
        logic       en_r;
        op_pool = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd63, 6'd0};

        rst_n = 1'b0; en = 1'b0; Op = '0; Funct = '0; exp_q = '0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", 11'd0);
        @(negedge clk) rst_n = 1'b1;

        step("rtype_add", 1'b1, 6'b000000, 6'b100000);
        check("add_fixed", 11'b1001000_010_0);
        step("rtype_sub", 1'b1, 6'b000000, 6'b100010);
        check("sub_fixed", 11'b1001000_110_0);
        step("rtype_and", 1'b1, 6'b000000, 6'b100100);
        step("rtype_or",  1'b1, 6'b000000, 6'b100101);
        step("rtype_slt", 1'b1, 6'b000000, 6'b101010);
        check("slt_fixed", 11'b1001000_111_0);
        step("rtype_bad_funct", 1'b1, 6'b000000, 6'b000111);
        check("bad_funct_fixed", ILL);
        step("lw_x",  1'b1, 6'b100011, 6'bxxxxxx);
        check("lw_fixed", 11'b0111000_010_0);
        step("sw_x",  1'b1, 6'b101011, 6'bxxxxxx);
        check("sw_fixed", 11'b0100100_010_0);
        step("beq_x", 1'b1, 6'b000100, 6'bxxxxxx);
        check("beq_fixed", 11'b0000010_110_0);
        step("op_3f", 1'b1, 6'b111111, 6'b100000);
        check("op_3f_fixed", ILL);

        step("hold_sw", 1'b1, 6'b101011, 6'b000000);
        step("hold_en0", 1'b0, 6'b100011, 6'b000000);
        check("hold_en0_fixed", 11'b0100100_010_0);
        step("hold_en1", 1'b1, 6'b100011, 6'b000000);
        check("hold_en1_fixed", 11'b0111000_010_0);

        step("addi", 1'b1, 6'b001000, 6'b000000);
        check("addi_fixed", IMM_JUMP ? 11'b0101000_010_0 : ILL);
        step("jump", 1'b1, 6'b000010, 6'b000000);
        check("jump_fixed", IMM_JUMP ? 11'b0000001_000_0 : ILL);

        for (int i = 0; i < 300; i++) begin
            op_r = op_pool[$urandom_range(0, 7)];
            if (op_pool[$urandom_range(0, 7)] == 6'd63) op_r = 6'($urandom);
            fn_r = ($urandom_range(0, 1) == 1) ? funct_tab[$urandom_range(0, 4)] : 6'($urandom);
            en_r = ($urandom_range(0, 3) != 0);
            step("random", en_r, op_r, fn_r);
        end

        // Reset between edges must clear immediately and discard the pending decode.
        step("pre_reset_lw", 1'b1, 6'b100011, 6'b000000);
        @(negedge clk);
        Op = 6'b000000; Funct = 6'b100000; en = 1'b1;
        #2 rst_n = 1'b0;
        exp_q = '0;
        #1 check("async_reset", 11'd0);
        @(posedge clk);
        #1 check("reset_held_over_edge", 11'd0);
        @(negedge clk) rst_n = 1'b1;
        step("post_reset_first", 1'b1, 6'b000100, 6'b000000);
        step("back_to_back_a", 1'b1, 6'b000000, 6'b100101);
        step("back_to_back_b", 1'b1, 6'b101011, 6'b000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
